// File: rtl/rv32i_pkg.sv
// Shared types and sizes for the RV32I instruction-memory boot path.
package rv32i_pkg;

  localparam int IMEM_DEPTH  = 256;
  localparam int IMEM_ADDR_W = 8;

  typedef enum logic [2:0] {
    CNT_LO = 3'd0,
    CNT_HI = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } loader_state_t;

endpackage

// File: rtl/loader_byte_packer.sv
// Packs stream bytes into little-endian 32-bit words and keeps a running XOR of them.
module loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  in_data,
  output logic [31:0] word_next,
  output logic        word_valid,
  output logic [7:0]  acc,
  output logic [1:0]  lane
);

  logic [31:0] word_q;

  // Shifting in from the top leaves the first byte of a word in bits 7:0.
  assign word_next  = {in_data, word_q[31:8]};
  assign word_valid = byte_en && (lane == 2'd3);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane   <= 2'd0;
      word_q <= 32'd0;
      acc    <= 8'd0;
    end else if (byte_en) begin
      lane   <= lane + 2'd1;
      word_q <= word_next;
      acc    <= acc ^ in_data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction SRAM writes, checksum check, core reset release.
module imem_loader
  import rv32i_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [2:0]        state
);

  // Stream handshake: a byte moves when in_valid && in_ready at the rising edge;
  // in_ready depends only on the state register, never on in_valid.
  loader_state_t state_q, state_d;

  logic [7:0]    cnt_lo_q;
  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] idx_q;
  logic [15:0]   count16;
  logic          xfer;
  logic          byte_en;
  logic          clear;
  logic [31:0]   word_next;
  logic          word_valid;
  logic [7:0]    acc;
  logic [1:0]    lane;

  assign xfer    = in_valid && in_ready;
  assign count16 = {in_data, cnt_lo_q};
  assign byte_en = (state_q == DATA) && xfer;
  assign clear   = (state_q == CNT_HI) && xfer;

  loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .byte_en    (byte_en),
    .in_data    (in_data),
    .word_next  (word_next),
    .word_valid (word_valid),
    .acc        (acc),
    .lane       (lane)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= CNT_LO;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CNT_LO: if (xfer) state_d = CNT_HI;
      CNT_HI: if (xfer) begin
        if (count16 == 16'd0 || count16 > 16'(DEPTH)) state_d = ERR;
        else                                          state_d = DATA;
      end
      DATA:   if (word_valid && (idx_q + 1'b1 == count_q)) state_d = CHECK;
      CHECK:  if (xfer) state_d = (in_data == acc) ? DONE : ERR;
      DONE:   state_d = DONE;
      ERR:    state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                 (state_q == DATA)   || (state_q == CHECK);
    done       = (state_q == DONE);
    error      = (state_q == ERR);
    core_reset = (state_q != DONE);
    state      = state_q;
  end

  // SRAM strobes default to idle each cycle, so a write lasts exactly one cycle
  // and a reset the cycle after a lane-3 byte drops the pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_lo_q <= 8'd0;
      count_q  <= '0;
      idx_q    <= '0;
      mem_csb  <= 1'b1;
      mem_web  <= 1'b1;
      mem_addr <= '0;
      mem_din  <= 32'd0;
    end else begin
      mem_csb <= 1'b1;
      mem_web <= 1'b1;
      if (state_q == CNT_LO && xfer) cnt_lo_q <= in_data;
      if (clear) begin
        count_q <= count16[ADDR_W:0];
        idx_q   <= '0;
      end
      if (word_valid) begin
        mem_csb  <= 1'b0;
        mem_web  <= 1'b0;
        mem_addr <= idx_q[ADDR_W-1:0];
        mem_din  <= word_next;
        idx_q    <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: directed frames, expected SRAM writes queued and checked by a monitor.
module tb_imem_loader;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_csb, mem_web;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic        core_reset, done, error;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail = 0;

  logic [39:0] exp_q[$];
  logic [31:0] data_w[256];
  logic        prev_strobe = 1'b0;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_csb    (mem_csb),
    .mem_web    (mem_web),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .core_reset (core_reset),
    .done       (done),
    .error      (error),
    .state      (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every write strobe is popped against the expected queue
  always @(negedge clk) begin
    if (!reset && !mem_csb) begin
      check("write_web", 40'(mem_web), 40'd0);
      check("strobe_one_cycle", 40'(prev_strobe), 40'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %h din %h", mem_addr, mem_din);
      end else begin
        check("write_addr_din", {mem_addr, mem_din}, exp_q.pop_front());
      end
    end
    prev_strobe = !reset && !mem_csb;
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_state", 40'(state), 40'(CNT_LO));
    check("rst_in_ready", 40'(in_ready), 40'd1);
    check("rst_csb_web", {38'd0, mem_csb, mem_web}, 40'd3);
    check("rst_addr_din", {mem_addr, mem_din}, 40'd0);
    check("rst_flags", {37'd0, core_reset, done, error}, 40'b100);
    exp_q.delete();
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit stall);
    if (stall) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    check("in_ready_mid_frame", 40'(in_ready), 40'd1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic fill_words(input int n, input int seed);
    for (int i = 0; i < n; i++)
      data_w[i] = {8'(i + seed), 8'(~i), 8'(i * 3 + seed), 8'hA5 ^ 8'(seed)};
  endtask

  // Sends count, n words from data_w, then checksum XOR corrupt; checks the outcome.
  task automatic load_frame(input int n, input logic [7:0] corrupt, input bit stall);
    logic [7:0] cs;
    logic [31:0] w;
    cs = 8'd0;
    drive_byte(8'(n), stall);
    drive_byte(8'(n >> 8), stall);
    for (int i = 0; i < n; i++) begin
      w = data_w[i];
      exp_q.push_back({8'(i), w});
      for (int b = 0; b < 4; b++) begin
        drive_byte(w[8*b +: 8], stall);
        cs = cs ^ w[8*b +: 8];
      end
    end
    drive_byte(cs ^ corrupt, stall);
    check("pre_cs_done", 40'(done), 40'd0);
    go_idle();
    if (corrupt == 8'd0) begin
      check("done_flags", {37'd0, core_reset, done, error}, 40'b010);
    end else begin
      check("err_flags", {37'd0, core_reset, done, error}, 40'b101);
    end
    check("post_in_ready", 40'(in_ready), 40'd0);
    #1;
    check("queue_drained", 40'(exp_q.size()), 40'd0);
  endtask

  task automatic illegal_count(input logic [7:0] lo, input logic [7:0] hi);
    drive_byte(lo, 1'b0);
    drive_byte(hi, 1'b0);
    go_idle();
    check("bad_count_error", {37'd0, core_reset, done, error}, 40'b101);
    repeat (3) @(negedge clk);
    check("bad_count_no_write", {39'd0, mem_csb}, 40'd1);
  endtask

  task automatic load_one_word_raw();
    exp_q.push_back({8'h00, 32'h00A00513});
    drive_byte(8'h01, 1'b0);
    drive_byte(8'h00, 1'b0);
    drive_byte(8'h13, 1'b0);
    drive_byte(8'h05, 1'b0);
    drive_byte(8'hA0, 1'b0);
    drive_byte(8'h00, 1'b0);
    drive_byte(8'hB6, 1'b0);
    check("one_word_pre_done", {38'd0, core_reset, done}, 40'b10);
    go_idle();
    check("one_word_done", {37'd0, core_reset, done, error}, 40'b010);
    #1;
    check("one_word_drained", 40'(exp_q.size()), 40'd0);
  endtask

  initial begin
    apply_reset();

    // single word with hand-computed bytes and checksum
    load_one_word_raw();
    repeat (2) @(negedge clk);
    check("done_sticky", {38'd0, done, in_ready}, 40'b10);

    // full memory, back-to-back
    apply_reset();
    fill_words(256, 7);
    load_frame(256, 8'h00, 1'b0);

    // bad checksum, error is permanent even with in_valid high
    apply_reset();
    fill_words(2, 1);
    load_frame(2, 8'h01, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("err_sticky", {37'd0, core_reset, error, in_ready}, 40'b110);
    in_valid = 1'b0;

    // illegal counts
    apply_reset();
    illegal_count(8'h00, 8'h00);
    apply_reset();
    illegal_count(8'h01, 8'h01);

    // stalled 3-word load
    apply_reset();
    fill_words(3, 9);
    load_frame(3, 8'h00, 1'b1);

    // reset after 6 data bytes, then a clean frame
    apply_reset();
    fill_words(2, 4);
    exp_q.push_back({8'h00, data_w[0]});
    drive_byte(8'h02, 1'b0);
    drive_byte(8'h00, 1'b0);
    for (int b = 0; b < 6; b++) drive_byte(data_w[b / 4][8*(b % 4) +: 8], 1'b0);
    apply_reset();
    load_one_word_raw();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
